// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter state type and one-hot helper
package arb_pkg;
    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;
    localparam int MAX_N = 1024;
    function automatic logic [MAX_N-1:0] onehot_from_idx(input logic [31:0] idx);
        return MAX_N'(1) << idx;
    endfunction
endpackage

// File: rtl/prio_encoder.sv
// prio_encoder: index of the highest set bit of a vector
module prio_encoder #(
    parameter  int WIDTH = 8,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             valid,
    output logic [IW-1:0]    idx
);
    assign valid = |vec;
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) idx = vec[i] ? IW'(i) : idx;
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered valid/ready grant
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic [N-1:0]  gnt_onehot_o,
    input  logic          gnt_ready_i
);
    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_eff;
    logic [N-1:0]  cand;
    logic [N-1:0]  masked;
    logic          m_valid;
    logic          u_valid;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] u_idx;
    logic [IW-1:0] pick;
    // on a handshake the pointer moves to the grant being accepted, so arbitrate against it now
    assign ptr_eff = (state == ARB_GRANT) ? gnt_idx_o : ptr;
    assign cand    = (state == ARB_GRANT) ? (req_i & ~gnt_onehot_o) : req_i;
    assign masked  = cand & (N'(onehot_from_idx(32'(ptr_eff))) - N'(1));
    assign pick    = m_valid ? m_idx : u_idx;
    prio_encoder #(.WIDTH(N)) u_masked (.vec(masked), .valid(m_valid), .idx(m_idx));
    prio_encoder #(.WIDTH(N)) u_full   (.vec(cand),   .valid(u_valid), .idx(u_idx));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            gnt_valid_o  <= 1'b0;
            gnt_idx_o    <= '0;
            gnt_onehot_o <= '0;
        end else if (state == ARB_IDLE || gnt_ready_i) begin
            ptr          <= ptr_eff;
            state        <= u_valid ? ARB_GRANT : ARB_IDLE;
            gnt_valid_o  <= u_valid;
            gnt_idx_o    <= pick;
            gnt_onehot_o <= u_valid ? N'(onehot_from_idx(32'(pick))) : '0;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed self-checking bench for rr_arbiter
module tb_rr_arbiter;
    localparam int N  = 8;
    localparam int IW = 3;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gnt_ready_i = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic          gnt_valid_o;
    logic [IW-1:0] gnt_idx_o;
    logic [N-1:0]  gnt_onehot_o;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_valid_o(gnt_valid_o),
        .gnt_idx_o(gnt_idx_o), .gnt_onehot_o(gnt_onehot_o), .gnt_ready_i(gnt_ready_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_i = '0;
        gnt_ready_i = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_i = 8'hFF;
        gnt_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({gnt_valid_o, gnt_idx_o, gnt_onehot_o} !== '0)
                $display("FAIL reset_hold[%0d]: got valid=%b idx=%0d onehot=%h, want 0/0/00", i, gnt_valid_o, gnt_idx_o, gnt_onehot_o);
            else passed++;
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd7 || gnt_onehot_o !== 8'h80)
            $display("FAIL reset_release: got valid=%b idx=%0d onehot=%h, want 1/7/80", gnt_valid_o, gnt_idx_o, gnt_onehot_o);
        else passed++;
    endtask

    task automatic test_full_rotation;
        int exp_idx[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        logic [N-1:0] eo;
        do_reset();
        req_i = 8'hFF;
        gnt_ready_i = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            eo = 8'd1 << exp_idx[i];
            total++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== IW'(exp_idx[i]) || gnt_onehot_o !== eo)
                $display("FAIL rotation[%0d]: got valid=%b idx=%0d onehot=%h, want 1/%0d/%h", i, gnt_valid_o, gnt_idx_o, gnt_onehot_o, exp_idx[i], eo);
            else passed++;
            tick();
        end
        gnt_ready_i = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset();
        req_i = 8'h12;
        gnt_ready_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd4 || gnt_onehot_o !== 8'h10)
                $display("FAIL backpressure_hold[%0d]: got valid=%b idx=%0d onehot=%h, want 1/4/10", i, gnt_valid_o, gnt_idx_o, gnt_onehot_o);
            else passed++;
            tick();
        end
        gnt_ready_i = 1'b1;
        tick();
        gnt_ready_i = 1'b0;
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd1 || gnt_onehot_o !== 8'h02)
            $display("FAIL backpressure_next: got valid=%b idx=%0d onehot=%h, want 1/1/02", gnt_valid_o, gnt_idx_o, gnt_onehot_o);
        else passed++;
    endtask

    task automatic test_wrap;
        do_reset();
        req_i = 8'h04;
        tick();
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd2)
            $display("FAIL wrap_setup: got valid=%b idx=%0d, want 1/2", gnt_valid_o, gnt_idx_o);
        else passed++;
        req_i = 8'h81;
        gnt_ready_i = 1'b1;
        tick();
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd0 || gnt_onehot_o !== 8'h01)
            $display("FAIL wrap_first: got valid=%b idx=%0d onehot=%h, want 1/0/01", gnt_valid_o, gnt_idx_o, gnt_onehot_o);
        else passed++;
        tick();
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd7 || gnt_onehot_o !== 8'h80)
            $display("FAIL wrap_second: got valid=%b idx=%0d onehot=%h, want 1/7/80", gnt_valid_o, gnt_idx_o, gnt_onehot_o);
        else passed++;
        gnt_ready_i = 1'b0;
    endtask

    task automatic test_lone_requester;
        logic ev;
        logic [N-1:0] eo;
        do_reset();
        req_i = 8'h08;
        gnt_ready_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ev = (i % 2 == 0);
            eo = ev ? 8'h08 : 8'h00;
            total++;
            if (gnt_valid_o !== ev || gnt_onehot_o !== eo || (ev && gnt_idx_o !== 3'd3))
                $display("FAIL lone[%0d]: got valid=%b idx=%0d onehot=%h, want valid=%b onehot=%h idx=3", i, gnt_valid_o, gnt_idx_o, gnt_onehot_o, ev, eo);
            else passed++;
            tick();
        end
        gnt_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_grant;
        do_reset();
        req_i = 8'h20;
        gnt_ready_i = 1'b1;
        tick();
        tick();
        gnt_ready_i = 1'b0;
        tick();
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd5)
            $display("FAIL midreset_setup: got valid=%b idx=%0d, want 1/5", gnt_valid_o, gnt_idx_o);
        else passed++;
        rst_n = 1'b0;
        tick();
        total++;
        if ({gnt_valid_o, gnt_idx_o, gnt_onehot_o} !== '0)
            $display("FAIL midreset_clear: got valid=%b idx=%0d onehot=%h, want 0/0/00", gnt_valid_o, gnt_idx_o, gnt_onehot_o);
        else passed++;
        rst_n = 1'b1;
        req_i = 8'h24;
        tick();
        total++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 3'd5 || gnt_onehot_o !== 8'h20)
            $display("FAIL midreset_first: got valid=%b idx=%0d onehot=%h, want 1/5/20", gnt_valid_o, gnt_idx_o, gnt_onehot_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_rotation();
        test_backpressure();
        test_wrap();
        test_lone_requester();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter with a registered valid/ready grant output, built around the common priority encoder. Sits directly downstream of a request vector (N requesters) and upstream of a single shared consumer (bus port, writeback slot, FU). Keeps a last-granted pointer so no requester starves, and holds a grant stable until the consumer accepts it.

## Interface
- N, default 8: number of requesters; N >= 2.
- IW, default $clog2(N): index width (derived; not overridden).

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_i  in  N  request vector; bit k = requester k wants the resource.
- gnt_valid_o  out  1  a grant is being presented.
- gnt_idx_o  out  IW  index of granted requester.
- gnt_onehot_o  out  N  one-hot of gnt_idx_o; all-zero when gnt_valid_o = 0.
- gnt_ready_i  in  1  consumer accepts the presented grant this cycle.

## Operation
- Base priority: highest index wins, the same rule as the priority encoder.
- Pointer ptr (IW bits) = index of last accepted grant; reset value 0.
- Arbitration, combinational from a candidate vector c:
  - masked = c & (bits strictly below ptr).
  - If masked != 0, pick the highest set bit of masked.
  - Else pick the highest set bit of c.
  - This rotates priority downward and wraps from 0 back to N-1.
- Two states, ARB_IDLE and ARB_GRANT.
- ARB_IDLE:
  - c = req_i.
  - If c != 0: register the pick into gnt_idx_o and go to ARB_GRANT.
  - Else stay in ARB_IDLE.
- ARB_GRANT:
  - gnt_valid_o = 1; gnt_idx_o and gnt_onehot_o are held constant.
  - If gnt_ready_i = 0: hold the grant.
  - If gnt_ready_i = 1 (handshake):
    - ptr <= gnt_idx_o.
    - Re-arbitrate with c = req_i & ~gnt_onehot_o, using the updated ptr value (the current gnt_idx_o).
    - If c != 0: load the new pick and stay in ARB_GRANT (back-to-back grant).
    - Else go to ARB_IDLE.
- A grant is never retracted. If the granted requester drops req_i while granted, the grant stays valid until handshake.
- Requesters keep req_i asserted until their grant is accepted.
- gnt_idx_o is always < N, for any N including non-powers of two.

## Timing
- Reset (rst_n = 0 at an edge): state = ARB_IDLE, ptr = 0, gnt_valid_o = 0, gnt_idx_o = 0, gnt_onehot_o = 0. Any in-flight grant is discarded.
- Latency: req_i rising at cycle t (state ARB_IDLE) gives gnt_valid_o = 1 at t+1.
- Throughput:
  - One grant per cycle with gnt_ready_i held high and at least 2 requesters active.
  - A lone persistent requester is granted every other cycle: the just-granted bit is excluded on the handshake cycle.
- Simultaneous handshake and req_i change: the handshake-cycle req_i value is used.
- Outputs are registered only; there is no combinational path from req_i or gnt_ready_i to any output.

## Structure
- Shared package arb_pkg holds:
  - typedef enum logic [0:0] arb_state_e { ARB_IDLE, ARB_GRANT }.
  - Function onehot_from_idx.
- Sub-module: two prio_encoder instances (WIDTH = N).
  - One on the masked vector, one on the unmasked vector.
  - Selection uses the masked encoder's valid output.
- Expected size: ~150 lines of RTL.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with req_i = 8'hFF.
  - Outputs stay 0 during reset.
  - Release at cycle t: gnt_valid_o = 1, gnt_idx_o = 7, gnt_onehot_o = 8'h80 at t+1.
- Full rotation: req_i = 8'hFF held, gnt_ready_i = 1.
  - Accepted grants: 7,6,5,4,3,2,1,0,7 on consecutive cycles.
- Backpressure: req_i = 8'h12, gnt_ready_i = 0 for 5 cycles.
  - gnt_idx_o = 4 is stable throughout.
  - gnt_ready_i = 1 for one cycle: the next cycle shows gnt_idx_o = 1.
- Wrap: after an accepted grant of 2 (ptr = 2), req_i = 8'h81 with ready = 1.
  - Grants are 0 then 7, in that order.
- Lone requester: req_i = 8'h08 held, ready = 1.
  - gnt_valid_o toggles 1,0,1,0; gnt_idx_o = 3 on every grant.
- Reset mid-grant: in ARB_GRANT with gnt_idx_o = 5, assert rst_n = 0 for 1 cycle.
  - All outputs are 0 the next cycle and ptr = 0.
  - With req_i = 8'h24 after release, the first grant is 5.
